// File: rtl/act_share_arbiter.sv
// Round-robin arbiter with burst locking that shares one activation unit among N_REQ requesters.
// Optional `ACT_ARB_PERF_CNT_EN adds busy/stall cycle counters (o_busy_cnt, o_stall_cnt).
module act_share_arbiter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned ACT_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic                        o_act_en,
  output logic                        o_act_valid,
  output logic [DATA_WIDTH-1:0]       o_act_data,
  input  logic                        i_act_valid,
  input  logic [DATA_WIDTH-1:0]       i_act_data,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]       o_rsp_data,
  output logic [ID_WIDTH-1:0]         o_rsp_id,
  output logic                        o_err
`ifdef ACT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                 o_busy_cnt,
  output logic [31:0]                 o_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                                 state_q;
  logic [ID_WIDTH-1:0]                    ptr_q;
  logic [ID_WIDTH-1:0]                    owner_q;
  logic [CW-1:0]                          cnt_q;
  logic [ACT_LATENCY-1:0]                 tag_v_q;
  logic [ACT_LATENCY-1:0][ID_WIDTH-1:0]   tag_id_q;
  logic                                   err_q;

  logic [ID_WIDTH-1:0] base;
  logic [ID_WIDTH-1:0] scan_idx;
  logic [ID_WIDTH-1:0] pick;
  logic                found;
  logic                cont;
  logic                gnt_valid;
  logic                rsp_hit;
  logic [ID_WIDTH-1:0] rsp_id_d;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    return (v == ID_WIDTH'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // In LOCK, a release re-arbitrates from owner+1 in the same cycle, so the
  // scan base is chosen before the search rather than after a state change.
  always_comb begin
    base     = ptr_q;
    cont     = 1'b0;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    if (state_q == LOCK) begin
      cont = i_req_valid[owner_q] && (cnt_q < CW'(MAX_BURST));
      base = wrap_inc(owner_q);
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = ID_WIDTH'((32'(base) + i) % N_REQ);
      if (!found && i_req_valid[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
    if (cont) begin
      found = 1'b1;
      pick  = owner_q;
    end
    gnt_valid = i_en && rst_n && found;
  end

  always_comb begin
    o_req_ready = gnt_valid ? (N_REQ'(1) << pick) : '0;
    o_act_valid = gnt_valid;
    o_act_en    = i_en;
    o_act_data  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_valid && (pick == ID_WIDTH'(k))) begin
        o_act_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (i_en) begin
      if (gnt_valid && cont) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (gnt_valid) begin
        if (MAX_BURST > 1) begin
          state_q <= LOCK;
          owner_q <= pick;
          cnt_q   <= CW'(1);
          ptr_q   <= base;
        end else begin
          state_q <= IDLE;
          ptr_q   <= wrap_inc(pick);
        end
      end else if (state_q == LOCK) begin
        state_q <= IDLE;
        ptr_q   <= base;
      end
    end
  end

  // Tag pipe shifts regardless of i_en so in-flight results still return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      tag_v_q  <= (tag_v_q << 1) | ACT_LATENCY'(gnt_valid);
      tag_id_q <= (tag_id_q << ID_WIDTH) | (ACT_LATENCY*ID_WIDTH)'(gnt_valid ? pick : '0);
      err_q    <= err_q | (i_act_valid != tag_v_q[ACT_LATENCY-1]);
    end
  end

  always_comb begin
    rsp_hit     = i_act_valid && tag_v_q[ACT_LATENCY-1];
    rsp_id_d    = tag_id_q[ACT_LATENCY-1];
    o_rsp_valid = rsp_hit ? (N_REQ'(1) << rsp_id_d) : '0;
    o_rsp_id    = rsp_hit ? rsp_id_d : '0;
    o_rsp_data  = rsp_hit ? i_act_data : '0;
    o_err       = err_q;
  end

`ifdef ACT_ARB_PERF_CNT_EN
  logic [31:0] busy_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if (gnt_valid) busy_q <= busy_q + 32'd1;
      if ((|i_req_valid) && !gnt_valid) stall_q <= stall_q + 32'd1;
    end
  end

  assign o_busy_cnt  = busy_q;
  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_act_share_arbiter.sv
// Directed bench: two arbiters (MAX_BURST=4 and 1), each fed by a clamp-to-+/-64 stub activation unit.
module tb_act_share_arbiter;

  localparam logic [15:0] REQ_D [4] = '{16'h0010, 16'hFF00, 16'h0100, 16'h0030};
  localparam logic [15:0] RSP_D [4] = '{16'h0010, 16'hFFC0, 16'h0040, 16'h0030};

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_v;
  logic [63:0] req_d;
  logic        force_av;

  logic [3:0]  a_rdy, b_rdy, a_rsp, b_rsp;
  logic        a_aen, b_aen, a_av, b_av, a_err, b_err;
  logic [15:0] a_ad, b_ad, a_rd, b_rd;
  logic [1:0]  a_rid, b_rid;
  logic        a_sv, b_sv;
  logic [15:0] a_sd, b_sd;
`ifdef ACT_ARB_PERF_CNT_EN
  logic [31:0] a_busy, a_stall, b_busy, b_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  act_share_arbiter #(.DATA_WIDTH(16), .N_REQ(4), .ID_WIDTH(2), .MAX_BURST(4), .ACT_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_req_valid(req_v), .i_req_data(req_d),
    .o_req_ready(a_rdy), .o_act_en(a_aen), .o_act_valid(a_av), .o_act_data(a_ad),
    .i_act_valid(a_sv | force_av), .i_act_data(a_sd),
    .o_rsp_valid(a_rsp), .o_rsp_data(a_rd), .o_rsp_id(a_rid), .o_err(a_err)
`ifdef ACT_ARB_PERF_CNT_EN
    , .o_busy_cnt(a_busy), .o_stall_cnt(a_stall)
`endif
  );

  act_share_arbiter #(.DATA_WIDTH(16), .N_REQ(4), .ID_WIDTH(2), .MAX_BURST(1), .ACT_LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_req_valid(req_v), .i_req_data(req_d),
    .o_req_ready(b_rdy), .o_act_en(b_aen), .o_act_valid(b_av), .o_act_data(b_ad),
    .i_act_valid(b_sv), .i_act_data(b_sd),
    .o_rsp_valid(b_rsp), .o_rsp_data(b_rd), .o_rsp_id(b_rid), .o_err(b_err)
`ifdef ACT_ARB_PERF_CNT_EN
    , .o_busy_cnt(b_busy), .o_stall_cnt(b_stall)
`endif
  );

  function automatic logic [15:0] clamp64(input logic [15:0] x);
    if ($signed(x) > 16'sd64)  return 16'h0040;
    if ($signed(x) < -16'sd64) return 16'hFFC0;
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sv <= 1'b0; a_sd <= '0; b_sv <= 1'b0; b_sd <= '0;
    end else begin
      a_sv <= a_av; a_sd <= clamp64(a_ad);
      b_sv <= b_av; b_sd <= clamp64(b_ad);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;   // 0: burst-4 instance, 1: burst-1 instance
    logic       rst;   // pulse reset before applying
    logic       en;
    logic [3:0] v;
    logic [3:0] rdy;
    logic [3:0] rsp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic r, input logic e,
                              input logic [3:0] v, input logic [3:0] rdy, input logic [3:0] rsp);
    vec_t t;
    t.sel = s; t.rst = r; t.en = e; t.v = v; t.rdy = rdy; t.rsp = rsp;
    return t;
  endfunction

  function automatic int unsigned oh2i(input logic [3:0] oh);
    for (int unsigned i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; req_v = '0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  g_rdy, g_rsp;
    logic        g_av, g_aen, g_err;
    logic [15:0] g_ad, g_rd, e_ad, e_rd;
    logic [1:0]  g_rid, e_rid;

    rst_n = 1'b0; en = 1'b0; req_v = '0; force_av = 1'b0;
    req_d = {REQ_D[3], REQ_D[2], REQ_D[1], REQ_D[0]};
    #12 rst_n = 1'b1;

    // burst-1: pure per-beat round robin
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'h1, 4'h0));
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h2, 4'h1));
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h4, 4'h2));
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h8, 4'h4));
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h1, 4'h8));
    vecs.push_back(mk(1, 0, 1, 4'hF, 4'h2, 4'h1));
    // burst-4: req0 for 6 beats vs req2 throughout
    vecs.push_back(mk(0, 1, 1, 4'h5, 4'h1, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h4, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h1, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h5, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'h4, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'h4, 4'h4));
    vecs.push_back(mk(0, 0, 1, 4'h4, 4'h4, 4'h4));
    // burst cut short: req1 drops after 2 beats, req3 takes over next cycle
    vecs.push_back(mk(0, 1, 1, 4'hA, 4'h2, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4'hA, 4'h2, 4'h2));
    vecs.push_back(mk(0, 0, 1, 4'h8, 4'h8, 4'h2));
    vecs.push_back(mk(0, 0, 1, 4'h8, 4'h8, 4'h8));
    // enable low for 3 cycles at cnt=2
    vecs.push_back(mk(0, 1, 1, 4'h3, 4'h1, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4'h3, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 0, 4'h3, 4'h0, 4'h1));
    vecs.push_back(mk(0, 0, 0, 4'h3, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 4'h3, 4'h0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4'h3, 4'h1, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4'h3, 4'h1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h3, 4'h2, 4'h1));
    vecs.push_back(mk(0, 0, 1, 4'h3, 4'h2, 4'h2));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      en = vecs[i].en; req_v = vecs[i].v;
      #2;
      g_rdy = vecs[i].sel ? b_rdy : a_rdy;
      g_av  = vecs[i].sel ? b_av  : a_av;
      g_ad  = vecs[i].sel ? b_ad  : a_ad;
      g_aen = vecs[i].sel ? b_aen : a_aen;
      g_rsp = vecs[i].sel ? b_rsp : a_rsp;
      g_rid = vecs[i].sel ? b_rid : a_rid;
      g_rd  = vecs[i].sel ? b_rd  : a_rd;
      g_err = vecs[i].sel ? b_err : a_err;
      e_ad  = (vecs[i].rdy == 4'h0) ? 16'h0 : REQ_D[oh2i(vecs[i].rdy)];
      e_rid = 2'(oh2i(vecs[i].rsp));
      e_rd  = (vecs[i].rsp == 4'h0) ? 16'h0 : RSP_D[e_rid];
      check($sformatf("v%0d_ready", i),    32'(g_rdy), 32'(vecs[i].rdy));
      check($sformatf("v%0d_act_valid", i), 32'(g_av), 32'(|vecs[i].rdy));
      check($sformatf("v%0d_act_data", i), 32'(g_ad),  32'(e_ad));
      check($sformatf("v%0d_act_en", i),   32'(g_aen), 32'(vecs[i].en));
      check($sformatf("v%0d_rsp_valid", i), 32'(g_rsp), 32'(vecs[i].rsp));
      check($sformatf("v%0d_rsp_id", i),   32'(g_rid), 32'(e_rid));
      check($sformatf("v%0d_rsp_data", i), 32'(g_rd),  32'(e_rd));
      check($sformatf("v%0d_err", i),      32'(g_err), 32'd0);
    end

    // spurious activation valid with empty tag pipe
    do_reset();
    @(negedge clk);
    en = 1'b0; req_v = '0; force_av = 1'b1;
    #2;
    check("err_not_yet", 32'(a_err), 32'd0);
    check("err_no_rsp",  32'(a_rsp), 32'd0);
    @(negedge clk);
    force_av = 1'b0;
    #2;
    check("err_set", 32'(a_err), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    check("err_sticky", 32'(a_err), 32'd1);
    check("err_other_inst", 32'(b_err), 32'd0);

    // async reset mid-burst on req2, then grant restarts from req0
    @(negedge clk);
    en = 1'b1; req_v = 4'h4;
    #2 check("mrst_pre_gnt1", 32'(a_rdy), 32'h4);
    @(negedge clk);
    #2 check("mrst_pre_gnt2", 32'(a_rdy), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_ready",     32'(a_rdy), 32'h0);
    check("mrst_act_valid", 32'(a_av),  32'h0);
    check("mrst_act_data",  32'(a_ad),  32'h0);
    check("mrst_act_en",    32'(a_aen), 32'h1);
    check("mrst_rsp_valid", 32'(a_rsp), 32'h0);
    check("mrst_rsp_id",    32'(a_rid), 32'h0);
    check("mrst_rsp_data",  32'(a_rd),  32'h0);
    check("mrst_err",       32'(a_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req_v = 4'hF;
    #2 check("mrst_first_gnt", 32'(a_rdy), 32'h1);
    @(negedge clk);
    #2 check("mrst_first_rsp", 32'(a_rsp), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/act_share_arbiter.md
Name: act_share_arbiter

Overview:
- Shares one sequential activation unit (1-cycle-latency, valid-qualified, e.g. the hardtanh datapath) between N_REQ requesters.
- Arbitration is round-robin with optional burst locking. Inputs feed the unit; results route back to the originating requester by a tag delay line matched to the unit latency.
- Sits between PE-array output ports and the single shared activation stage.

Parameters:
- DATA_WIDTH, 16, 2's-complement operand width, passed through unchanged.
- N_REQ, 4, number of requesters (≥2).
- ID_WIDTH, 2, clog2(N_REQ).
- MAX_BURST, 4, max consecutive beats one requester may hold the grant (≥1; 1 = pure per-beat round robin).
- ACT_LATENCY, 1, activation unit input-to-output latency in cycles (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  global enable; low = no new grants.
- i_req_valid  in  N_REQ  per-requester data valid.
- i_req_data  in  N_REQ*DATA_WIDTH  packed requester data, requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  N_REQ  one-hot grant; a beat transfers when valid & ready.
- o_act_en  out  1  activation unit enable (= i_en).
- o_act_valid  out  1  activation unit input valid.
- o_act_data  out  DATA_WIDTH  activation unit input data.
- i_act_valid  in  1  activation unit output valid.
- i_act_data  in  DATA_WIDTH  activation unit output data.
- o_rsp_valid  out  N_REQ  one-hot result valid, per requester.
- o_rsp_data  out  DATA_WIDTH  result data, shared bus.
- o_rsp_id  out  ID_WIDTH  requester index of current result.
- o_err  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (async, rst_n low): state IDLE, ptr=0, burst cnt=0, tag pipe cleared. All outputs 0 except o_act_en, which follows i_en. In-flight results are dropped.
- Grant path is combinational from i_req_valid and registered state. o_act_valid = |o_req_ready. o_act_data = data of granted requester, 0 when none.
- IDLE: if i_en, grant the first asserted i_req_valid searching cyclically from ptr.
  - MAX_BURST>1 → LOCK, owner=k, cnt=1.
  - MAX_BURST=1 → stay IDLE, ptr=(k+1) mod N_REQ.
- LOCK: if i_en, owner valid, and cnt<MAX_BURST → grant owner, cnt++.
  - Otherwise release in the same cycle: ptr=(owner+1) mod N_REQ, re-arbitrate as IDLE. No bubble cycle.
  - If the release re-arbitration grants k, the block re-enters LOCK with owner=k, cnt=1.
- i_en low: no grants; state, ptr and cnt frozen; tag pipe keeps shifting so in-flight results still return.
- Tag pipe: ACT_LATENCY registered stages of {valid, id}. Stage 0 loads {o_act_valid, granted id}.
- Response (combinational from last tag stage and i_act_*):
  - When i_act_valid & tag valid: o_rsp_valid = onehot(tag id), o_rsp_data = i_act_data, o_rsp_id = tag id.
  - Otherwise all zero.
- There is no response backpressure; requesters must always accept results.
- o_err set (sticky until reset) when i_act_valid ≠ last tag valid in any cycle.
- Throughput: 1 beat/cycle. Request-to-response latency = ACT_LATENCY cycles.

Optional Feature:
- Macro ACT_ARB_PERF_CNT_EN.
- Defined: adds output o_busy_cnt[31:0], counting cycles with o_act_valid=1, and output o_stall_cnt[31:0], counting cycles with any i_req_valid bit set but no grant. Both counters wrap at 2^32 and clear on reset.
- Undefined: neither port nor counter exists.

Test Plan:
- N_REQ=4, MAX_BURST=1, all valid constantly, i_en=1 → grants cycle 0,1,2,3,0,…. Each o_rsp_valid arrives exactly 1 cycle after its grant, with o_rsp_id matching.
- MAX_BURST=4, req0 valid for 6 beats, req2 valid throughout → grant req0×4, req2×4, req0×2, then req2 continuously. No idle cycle at any handover.
- Burst cut short: req1 drops valid after 2 beats, req3 valid → req3 is granted in the very next cycle.
- i_en low for 3 cycles mid-burst (cnt=2) → no grants, pending result still delivered. The burst resumes with cnt=2, finishing after 2 more beats.
- Stub unit clamps to ±64 (DATA_WIDTH=16). Drive req2 data 0x0100 → o_rsp_data 0x0040 on req2. Drive req1 data 0xFF00 → 0xFFC0 on req1.
- Force i_act_valid=1 with an empty tag pipe → o_err=1 next cycle and stays 1. Assert rst_n low mid-burst → all outputs 0 and the next grant starts from requester 0.
